// File: rtl/uart_tx_fifo.sv
// Transmit FIFO plus drain controller: buffers host bytes and hands them one at a
// time to the UART transmitter through a Tx_Start / Tx_Busy handshake.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic [DATA_BITS-1:0]                 Tx_Data,
  input  logic                                 Write_En,
  input  logic                                 Tx_Busy,
  output logic [DATA_BITS-1:0]                 Data_Out,
  output logic                                 Tx_Start,
  output logic                                 FIFO_Empty,
  output logic                                 FIFO_Full,
  output logic                                 FIFO_Overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      Count,
  output logic [1:0]                           Dbg_State
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]          wptr_q, wptr_d;
  logic [PW-1:0]          rptr_q, rptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   empty_q, empty_d;
  logic                   full_q, full_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   tx_start_q, tx_start_d;
  logic                   pop;
  logic                   wr_acc;

  // Handshake: a character is handed over by a one-cycle Tx_Start with Data_Out
  // valid; the transmitter acknowledges by raising Tx_Busy (at most one cycle
  // later) and signals completion by dropping it. A pop is only issued from IDLE
  // when Tx_Busy is low, so a start is never issued into a busy transmitter.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && !Tx_Busy) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (Tx_Busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!Tx_Busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Full is the pre-edge registered flag, so a write colliding with a pop while
  // full is dropped rather than squeezed in.
  always_comb begin
    wr_acc     = Write_En && !full_q;
    ovf_d      = ovf_q | (Write_En & full_q);
    wptr_d     = wr_acc ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
    data_out_d = pop ? mem_q[rptr_q] : data_out_q;
    case ({wr_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(FIFO_DEPTH));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
      data_out_q <= '0;
      tx_start_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
      data_out_q <= data_out_d;
      tx_start_q <= tx_start_d;
      if (wr_acc) begin
        mem_q[wptr_q] <= Tx_Data;
      end
    end
  end

  assign Data_Out      = data_out_q;
  assign Tx_Start      = tx_start_q;
  assign FIFO_Empty    = empty_q;
  assign FIFO_Full     = full_q;
  assign FIFO_Overflow = ovf_q;
  assign Count         = count_q;
  assign Dbg_State     = state_q;

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer for the UART: the host writes bytes into a circular FIFO, and a control FSM drains them one frame at a time into the UART transmitter using a start/busy handshake. It is the transmit-path counterpart of the receive FIFO and sits between the host write port and the transmitter's parallel load port. It is fully synchronous to one clock.

## Interface

- DATA_BITS, 8, width of one character
- FIFO_DEPTH, 4, number of entries; power of two, at least 2
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- Tx_Data  input  DATA_BITS  host write data
- Write_En  input  1  host write request, sampled every rising edge
- Tx_Busy  input  1  transmitter is shifting a frame
- Data_Out  output  DATA_BITS  character presented to the transmitter
- Tx_Start  output  1  one-cycle load/start pulse to the transmitter
- FIFO_Empty  output  1  count == 0
- FIFO_Full  output  1  count == FIFO_DEPTH
- FIFO_Overflow  output  1  sticky flag: a write was dropped
- Count  output  $clog2(FIFO_DEPTH+1)  entries currently stored

## Operation

- Storage: array of FIFO_DEPTH entries. WPtr and RPtr are $clog2(FIFO_DEPTH) bits wide and wrap naturally modulo FIFO_DEPTH. Count is tracked separately, so full and empty are never ambiguous.
- Write: when Write_En=1 and FIFO_Full=0 at an edge, Tx_Data goes to array[WPtr], WPtr increments, and Count increments.
- Dropped write: when Write_En=1 and FIFO_Full=1, the write is discarded, FIFO_Overflow is set, and array, WPtr and Count are unchanged.
  - FIFO_Overflow clears only on Rst.
  - Full is the registered pre-edge value, so a write at the same edge as a pop while full is still dropped.
- Pop: performed only by the FSM in IDLE. It loads Data_Out from array[RPtr], then increments RPtr and decrements Count.
- Simultaneous write and pop (not full): both take effect and Count is unchanged.
- FSM states:
  - IDLE: if FIFO_Empty=0 and Tx_Busy=0, pop, set Tx_Start=1 and go to START. Otherwise stay.
  - START: Tx_Start=0 and go to WAIT_BUSY.
  - WAIT_BUSY: stay until Tx_Busy=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until Tx_Busy=0, then go to IDLE.
- Data_Out: registered. It changes only on a pop and holds its value through the whole frame.
- Flags: FIFO_Empty, FIFO_Full and Count are registered and consistent with each other at every cycle.

## Timing

- Reset values:
  - Data_Out = 0, Tx_Start = 0
  - FIFO_Empty = 1, FIFO_Full = 0, FIFO_Overflow = 0, Count = 0
  - WPtr = RPtr = 0, state = IDLE, array cleared
- Reset mid-frame: all of the above apply immediately, regardless of Clk. The transmitter's in-flight frame is not aborted by this block. After release the FSM is in IDLE and waits for Tx_Busy=0 before any new start.
- Write-to-start latency, from write into an empty FIFO with FSM in IDLE and Tx_Busy=0:
  - write at edge k
  - FIFO_Empty low after edge k
  - pop and Tx_Start high after edge k+1
  - Tx_Start low after edge k+2
- Tx_Start is high for exactly one cycle per popped character. It is never asserted while Tx_Busy=1 is sampled in IDLE.
- Back-to-back: the next Tx_Start comes 1 cycle after the IDLE edge that samples Tx_Busy=0, provided the FIFO is non-empty.
- Handshake requirement: the transmitter must raise Tx_Busy no later than the cycle after Tx_Start. If it never does, the FSM stays in WAIT_BUSY; no timeout is implemented.

## Test plan

- Reset: drive Rst high mid-frame with 3 entries stored -> all outputs at reset values; no Tx_Start after release until a new write arrives.
- Single character: write 0xA5 to an empty FIFO, with a transmitter model that raises Tx_Busy 1 cycle after Tx_Start and holds it for 10 cycles -> Tx_Start high exactly one cycle, 1 cycle after FIFO_Empty falls; Data_Out=0xA5 stable until Tx_Busy falls; Count returns to 0.
- Ordering and wrap: write 0x01..0x06 in two bursts so the pointers wrap (DEPTH=4) -> transmitter receives 0x01..0x06 in order; exactly 6 Tx_Start pulses.
- Overflow: with Tx_Busy held high, write 5 bytes 0x10..0x14 -> FIFO_Full=1 after the 4th write, 0x14 dropped, FIFO_Overflow=1 and stays 1; the transmitter later receives 0x10..0x13 only.
- Simultaneous write/pop: Count=1 in IDLE, write at the pop edge -> Count stays 1; FIFO_Empty never asserts.
- Busy gating: Tx_Busy=1 while the FIFO is non-empty in IDLE -> no Tx_Start until 1 cycle after Tx_Busy falls.
